// File: rtl/pipeline_muldiv_if.sv
// Request/result bundle between an issuing pipeline stage and pipeline_muldiv.
// The issuer uses the master view; the multiply/divide unit uses the slave view.
interface pipeline_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [5:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             flush;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             done;
   logic             op_error;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
      input  req_ready, busy, hi, lo, done, op_error
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
      output req_ready, busy, hi, lo, done, op_error
   );
endinterface

// File: rtl/pipeline_muldiv.sv
// Iterative HI/LO multiply/divide unit: STEP_BITS result bits per RUN cycle on operand
// magnitudes, with sign correction and the divide corner cases applied in a single FIX cycle.
module pipeline_muldiv #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned STEP_BITS = 1
) (
   input logic              clk,
   input logic              rst,
   pipeline_muldiv_if.slave bus
);

   localparam int unsigned N    = WIDTH / STEP_BITS;
   localparam int unsigned CntW = $clog2(N + 1);

   localparam logic [5:0] OpMult  = 6'b000100;
   localparam logic [5:0] OpMthi  = 6'b000101;
   localparam logic [5:0] OpMtlo  = 6'b000110;
   localparam logic [5:0] OpMultu = 6'b000111;
   localparam logic [5:0] OpDiv   = 6'b001000;
   localparam logic [5:0] OpDivu  = 6'b001001;

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic               is_div_q, is_div_d;
   logic               b_zero_q, b_zero_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               op_error_q, op_error_d;

   logic               accept;
   logic               signed_op;
   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;

   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     top;
   logic [WIDTH:0]     sum;
   logic               qbit;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign bus.req_ready = (state_q == StIdle) && !bus.flush;
   assign bus.busy      = (state_q != StIdle);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.done      = done_q;
   assign bus.op_error  = op_error_q;

   assign accept = bus.req_valid && bus.req_ready;

   always_comb begin
      signed_op = (bus.req_op == OpMult) || (bus.req_op == OpDiv);
      sign_a    = signed_op && bus.req_a[WIDTH-1];
      sign_b    = signed_op && bus.req_b[WIDTH-1];
      mag_a     = sign_a ? -bus.req_a : bus.req_a;
      mag_b     = sign_b ? -bus.req_b : bus.req_b;
   end

   // Multiply: shift-add with the multiplier in the low half of acc.
   // Divide: restoring, remainder in the high half, quotient shifted into the low half.
   always_comb begin
      acc_step = acc_q;
      top      = '0;
      sum      = '0;
      qbit     = 1'b0;
      for (int i = 0; i < STEP_BITS; i++) begin
         if (is_div_q) begin
            top  = acc_step[2*WIDTH-1:WIDTH-1];
            qbit = (top >= {1'b0, opnd_q});
            if (qbit) begin
               top = top - {1'b0, opnd_q};
            end
            acc_step = {top[WIDTH-1:0], acc_step[WIDTH-2:0], qbit};
         end else begin
            sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]} +
                       (acc_step[0] ? {1'b0, opnd_q} : '0);
            acc_step = {sum, acc_step[WIDTH-1:1]};
         end
      end
   end

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      a_d        = a_q;
      is_div_d   = is_div_q;
      b_zero_d   = b_zero_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      op_error_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               unique case (bus.req_op)
                  OpMthi: begin
                     hi_d   = bus.req_a;
                     done_d = 1'b1;
                  end
                  OpMtlo: begin
                     lo_d   = bus.req_a;
                     done_d = 1'b1;
                  end
                  OpMult, OpMultu: begin
                     state_d   = StRun;
                     cnt_d     = '0;
                     is_div_d  = 1'b0;
                     opnd_d    = mag_a;
                     acc_d     = {{WIDTH{1'b0}}, mag_b};
                     a_d       = bus.req_a;
                     b_zero_d  = (bus.req_b == '0);
                     neg_d     = sign_a ^ sign_b;
                     rem_neg_d = 1'b0;
                  end
                  OpDiv, OpDivu: begin
                     state_d   = StRun;
                     cnt_d     = '0;
                     is_div_d  = 1'b1;
                     opnd_d    = mag_b;
                     acc_d     = {{WIDTH{1'b0}}, mag_a};
                     a_d       = bus.req_a;
                     b_zero_d  = (bus.req_b == '0);
                     neg_d     = sign_a ^ sign_b;
                     rem_neg_d = sign_a;
                  end
                  default: begin
                     done_d     = 1'b1;
                     op_error_d = 1'b1;
                  end
               endcase
            end
         end
         StRun: begin
            if (bus.flush) begin
               state_d = StIdle;
            end else begin
               acc_d = acc_step;
               if (cnt_q == CntW'(N - 1)) begin
                  state_d = StFix;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!bus.flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (b_zero_q) begin
                  // Divide by zero is not trapped: all-ones quotient, dividend kept in HI.
                  hi_d = a_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         a_q        <= '0;
         is_div_q   <= 1'b0;
         b_zero_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         op_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         a_q        <= a_d;
         is_div_q   <= is_div_d;
         b_zero_q   <= b_zero_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         op_error_q <= op_error_d;
      end
   end

endmodule

// File: tb/tb_pipeline_muldiv.sv
// Bench for pipeline_muldiv: transaction-level HI/LO model checked every cycle on a
// WIDTH=32/STEP_BITS=1 instance, plus directed literal checks and a STEP_BITS=4 instance.
module tb_pipeline_muldiv;

   localparam logic [5:0] OpMult  = 6'b000100;
   localparam logic [5:0] OpMthi  = 6'b000101;
   localparam logic [5:0] OpMtlo  = 6'b000110;
   localparam logic [5:0] OpMultu = 6'b000111;
   localparam logic [5:0] OpDiv   = 6'b001000;
   localparam logic [5:0] OpDivu  = 6'b001001;
   localparam int         N       = 32;

   logic clk;
   logic rst;

   pipeline_muldiv_if #(.WIDTH(32)) bus ();
   pipeline_muldiv_if #(.WIDTH(32)) bus4 ();

   pipeline_muldiv #(.WIDTH(32), .STEP_BITS(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipeline_muldiv #(.WIDTH(32), .STEP_BITS(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   bit busy_seen;

   // Model state: m_busy counts edges left until the result lands (0 = idle).
   int          m_busy;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_done, m_err;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [9];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_res(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] r;
      longint      la, lb;
      int          sa, sb, q, m;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         OpMult:  r = la * lb;
         OpMultu: r = {32'b0, a} * {32'b0, b};
         OpDiv: begin
            if (b == 32'h0) r = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else begin
               q = sa / sb;
               m = sa % sb;
               r = {m, q};
            end
         end
         OpDivu: begin
            if (b == 32'h0) r = {a, 32'hFFFFFFFF};
            else r = {a % b, a / b};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Per-cycle compare, then advance the model with the inputs the next edge samples.
   initial begin
      logic [63:0] res;
      m_busy = 0;
      m_hi   = '0;
      m_lo   = '0;
      p_hi   = '0;
      p_lo   = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("cyc_busy", bus.busy, m_busy != 0);
         chk("cyc_ready", bus.req_ready, (m_busy == 0) && !bus.flush);
         chk("cyc_hi", bus.hi, m_hi);
         chk("cyc_lo", bus.lo, m_lo);
         chk("cyc_done", bus.done, m_done);
         chk("cyc_err", bus.op_error, m_err);
         if (bus.done) done_cnt++;
         if (bus.op_error) err_cnt++;
         if (bus.busy) busy_seen = 1'b1;
         m_done = 1'b0;
         m_err  = 1'b0;
         if (rst) begin
            m_busy = 0;
            m_hi   = '0;
            m_lo   = '0;
         end else if (m_busy > 0) begin
            if (bus.flush) m_busy = 0;
            else if (m_busy == 1) begin
               m_hi   = p_hi;
               m_lo   = p_lo;
               m_done = 1'b1;
               m_busy = 0;
            end else m_busy--;
         end else if (bus.req_valid && !bus.flush) begin
            case (bus.req_op)
               OpMthi: begin
                  m_hi   = bus.req_a;
                  m_done = 1'b1;
               end
               OpMtlo: begin
                  m_lo   = bus.req_a;
                  m_done = 1'b1;
               end
               OpMult, OpMultu, OpDiv, OpDivu: begin
                  res    = model_res(bus.req_op, bus.req_a, bus.req_b);
                  p_hi   = res[63:32];
                  p_lo   = res[31:0];
                  m_busy = N + 1;
               end
               default: begin
                  m_done = 1'b1;
                  m_err  = 1'b1;
               end
            endcase
         end
      end
   end

   // Called at posedge+1 with the unit idle; returns just after the accepting edge.
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      i = 0;
      while (bus.busy && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk({name, "_timeout"}, bus.busy, 1'b0);
   endtask

   task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int d0;
      d0 = done_cnt;
      issue(op, a, b);
      wait_idle(name);
      @(posedge clk);
      #1;
      chk({name, "_hi"}, bus.hi, exp_hi);
      chk({name, "_lo"}, bus.lo, exp_lo);
      chk({name, "_done_cnt"}, done_cnt - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          d0, e0;
      logic [31:0] h0, l0;

      vecs[0] = {OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[1] = {OpDivu,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
      vecs[2] = {OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
      vecs[3] = {OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
      vecs[4] = {OpDiv,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[5] = {OpDiv,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[6] = {OpDivu,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[7] = {OpMult,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0,        32'd15};
      vecs[8] = {OpMultu, 32'h12345678, 32'h10,       32'h1,        32'h23456780};

      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.flush      = 1'b0;
      bus4.req_valid = 1'b0;
      bus4.req_op    = '0;
      bus4.req_a     = '0;
      bus4.req_b     = '0;
      bus4.flush     = 1'b0;
      busy_seen      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_hi", bus.hi, 32'h0);
      chk("rst_lo", bus.lo, 32'h0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ready", bus.req_ready, 1'b1);

      // MULT with exact edge count: busy through 32 edges, result on the 33rd.
      d0 = done_cnt;
      issue(OpMult, 32'hFFFFFFFE, 32'd3);
      repeat (N) @(posedge clk);
      #1;
      chk("mult_busy_at_32", bus.busy, 1'b1);
      chk("mult_ready_busy", bus.req_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("mult_busy_at_33", bus.busy, 1'b0);
      chk("mult_hi", bus.hi, 32'hFFFFFFFF);
      chk("mult_lo", bus.lo, 32'hFFFFFFFA);
      chk("mult_done", bus.done, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("mult_done_cnt", done_cnt - d0, 1);

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi,
                vecs[i].lo);
      end

      // Back-to-back MTHI/MTLO.
      d0            = done_cnt;
      busy_seen     = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = OpMthi;
      bus.req_a     = 32'h1234;
      @(posedge clk);
      #1;
      bus.req_op = OpMtlo;
      bus.req_a  = 32'h5678;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mthi_hi", bus.hi, 32'h1234);
      chk("mtlo_lo", bus.lo, 32'h5678);
      chk("mtx_done_cnt", done_cnt - d0, 2);
      chk("mtx_busy_seen", busy_seen, 1'b0);

      // Unknown opcode.
      d0 = done_cnt;
      e0 = err_cnt;
      issue(6'b111111, 32'hDEAD, 32'hBEEF);
      @(posedge clk);
      #1;
      chk("bad_op_err_cnt", err_cnt - e0, 1);
      chk("bad_op_done_cnt", done_cnt - d0, 1);
      chk("bad_op_hi", bus.hi, 32'h1234);
      chk("bad_op_lo", bus.lo, 32'h5678);

      // Flush in IDLE blocks acceptance.
      bus.flush = 1'b1;
      issue(OpMthi, 32'hCAFE, 32'h0);
      bus.flush = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_flush_hi", bus.hi, 32'h1234);

      // Flush on RUN cycle 10; a request during RUN must be ignored.
      d0 = done_cnt;
      h0 = bus.hi;
      l0 = bus.lo;
      issue(OpMult, 32'd9, 32'd9);
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = OpMtlo;
      bus.req_a     = 32'hAAAA;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush_busy", bus.busy, 1'b0);
      chk("flush_hi", bus.hi, h0);
      chk("flush_lo", bus.lo, l0);
      @(posedge clk);
      #1;
      chk("flush_done_cnt", done_cnt - d0, 0);
      run_op("after_flush", OpMultu, 32'd3, 32'd4, 32'd0, 32'd12);

      // Reset on RUN cycle 5.
      d0 = done_cnt;
      issue(OpMult, 32'd2, 32'd3);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_hi", bus.hi, 32'h0);
      chk("midrst_lo", bus.lo, 32'h0);
      chk("midrst_busy", bus.busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_done_cnt", done_cnt - d0, 0);

      // STEP_BITS=4 instance: result after 9 edges.
      for (int k = 0; k < 2; k++) begin
         bus4.req_valid = 1'b1;
         bus4.req_op    = (k == 0) ? OpMult : OpDiv;
         bus4.req_a     = (k == 0) ? 32'd5 : 32'hFFFFFFF9;
         bus4.req_b     = (k == 0) ? 32'd6 : 32'd2;
         @(posedge clk);
         #1;
         bus4.req_valid = 1'b0;
         repeat (8) @(posedge clk);
         #1;
         chk($sformatf("s4_%0d_busy8", k), bus4.busy, 1'b1);
         chk($sformatf("s4_%0d_done8", k), bus4.done, 1'b0);
         @(posedge clk);
         #1;
         chk($sformatf("s4_%0d_busy9", k), bus4.busy, 1'b0);
         chk($sformatf("s4_%0d_done9", k), bus4.done, 1'b1);
         chk($sformatf("s4_%0d_hi", k), bus4.hi, (k == 0) ? 32'h0 : 32'hFFFFFFFF);
         chk($sformatf("s4_%0d_lo", k), bus4.lo, (k == 0) ? 32'd30 : 32'hFFFFFFFD);
         @(posedge clk);
         #1;
         chk($sformatf("s4_%0d_done_off", k), bus4.done, 1'b0);
      end

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_muldiv.md
PIPELINE_MULDIV -- requirements
Module: pipeline_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have parameter STEP_BITS, default 1, bits retired per RUN cycle; must divide WIDTH; N = WIDTH/STEP_BITS.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  operation request.
REQ-006 SHALL have port req_ready  output  1  request acceptable this cycle.
REQ-007 SHALL have port req_op  input  6  opcode: 000100 MULT, 000111 MULTU, 001000 DIV, 001001 DIVU, 000101 MTHI, 000110 MTLO.
REQ-008 SHALL have port req_a  input  WIDTH  multiplicand/dividend/MTHI-MTLO source.
REQ-009 SHALL have port req_b  input  WIDTH  multiplier/divisor.
REQ-010 SHALL have port flush  input  1  abort in-flight operation.
REQ-011 SHALL have port busy  output  1  HI/LO not yet valid; MFHI/MFLO issuer stalls while high.
REQ-012 SHALL have port hi  output  WIDTH  HI register.
REQ-013 SHALL have port lo  output  WIDTH  LO register.
REQ-014 SHALL have port done  output  1  one-cycle pulse: HI/LO just updated.
REQ-015 SHALL have port op_error  output  1  one-cycle pulse: unknown opcode accepted.

Function
REQ-016 SHALL implement states IDLE, RUN, FIX; req_ready = (state==IDLE) && !flush; busy = (state!=IDLE).
REQ-017 SHALL accept a request on a rising edge with req_valid && req_ready; operands and op latched then.
REQ-018 SHALL, for MTHI/MTLO, write req_a to hi/lo on the accepting edge, stay IDLE, pulse done next cycle.
REQ-019 SHALL, for MULT/MULTU/DIV/DIVU, enter RUN for exactly N cycles, then FIX for one cycle, then IDLE.
REQ-020 SHALL update hi/lo and assert done on the FIX->IDLE edge; total latency accept-edge to visible result = N+1 edges.
REQ-021 SHALL, for signed ops, iterate on magnitudes and apply sign in FIX: product sign a^b; quotient sign a^b; remainder sign of a.
REQ-022 SHALL produce MULT/MULTU: {hi,lo} = full 2*WIDTH product.
REQ-023 SHALL produce DIV/DIVU: lo = quotient, hi = remainder, truncating toward zero.
REQ-024 SHALL, on divisor zero, produce lo = all ones, hi = req_a, done normal, no error.
REQ-025 SHALL, on DIV most-negative / -1, produce lo = most-negative, hi = 0.
REQ-026 SHALL, for any other opcode, accept, leave hi/lo unchanged, pulse op_error and done next cycle.
REQ-027 SHALL, on flush in RUN or FIX, return to IDLE next edge, hi/lo unchanged, no done.
REQ-028 SHALL ignore flush in IDLE, other than blocking acceptance that cycle.
REQ-029 SHALL hold req_ready low in RUN/FIX; requests presented then are not accepted.
REQ-030 SHALL deassert done and op_error at every cycle other than the specified pulses.

Reset
REQ-031 SHALL, on rst, force state IDLE, hi=0, lo=0, done=0, op_error=0; rst has priority over flush and requests.
REQ-032 SHALL, on rst mid-operation, discard the operation with no done pulse.

Verification
REQ-033 SHALL cover (WIDTH=32, STEP_BITS=1): MULT a=0xFFFFFFFE, b=3 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse once.
REQ-034 SHALL cover DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=1.
REQ-036 SHALL cover MTHI 0x1234 then MTLO 0x5678 back-to-back -> hi=0x1234, lo=0x5678, two done pulses, busy never high.
REQ-037 SHALL cover flush at RUN cycle 10 of MULT -> IDLE next edge, hi/lo retain prior values, no done; next request accepted.
REQ-038 SHALL cover rst at RUN cycle 5 -> hi=lo=0, busy=0, no done; STEP_BITS=4 MULT 5*6 -> lo=30 after 9 edges.
